mealy_seq_detect_param: RTL
===========================

MEALY_SEQ_DETECT_PARAM -- requirements
Module: mealy_seq_detect_param

Parameters
REQ-001 The block SHALL have parameter MAX_LEN, default 8, the longest supported pattern length (2..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, the width of the match counter.

Interface
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 x  input  1  serial data bit, one per cycle, qualified by en.
REQ-006 en  input  1  bit-valid; when low the detector ignores x and holds its state.
REQ-007 load  input  1  one-cycle strobe that captures cfg_pat, cfg_mask, cfg_len and cfg_ovl.
REQ-008 cfg_pat  input  MAX_LEN  pattern; bit len-1 is the oldest bit, bit 0 is the newest bit.
REQ-009 cfg_mask  input  MAX_LEN  don't-care mask; a 1 excludes that pattern bit from comparison.
REQ-010 cfg_len  input  $clog2(MAX_LEN+1)  pattern length; legal range 1..MAX_LEN.
REQ-011 cfg_ovl  input  1  mode: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-012 z  output  1  Mealy match output, combinational from the registered state, x and en.
REQ-013 match_cnt  output  CNT_W  registered count of matches.
REQ-014 cfg_err  output  1  registered pulse, one cycle long, flagging a rejected load.

Function
REQ-015 The block SHALL keep a history shift register hist[MAX_LEN-2:0] of past accepted bits, with the newest bit at hist[0].
REQ-016 The block SHALL keep a fill counter of valid history bits that saturates at MAX_LEN-1.
REQ-017 The compare window SHALL be w = {hist, x}, restricted to its low len bits.
REQ-018 z SHALL be 1 when all of the following hold: en=1, fill >= len-1, and ((w ^ pat) & ~mask) over the low len bits is zero.
REQ-019 When len=1, z SHALL depend on x alone, matched against pat[0] under mask[0].
REQ-020 On an edge with en=1 and z=0, hist SHALL shift in x and fill SHALL increment, saturating.
REQ-021 On an edge with en=1, z=1 and ovl=1, hist SHALL shift in x and fill SHALL increment, so matches may share bits.
REQ-022 On an edge with en=1, z=1 and ovl=0, hist SHALL shift in x and fill SHALL be set to 0, so the matched bits are consumed.
REQ-023 On every edge with z=1, match_cnt SHALL increment and saturate at 2^CNT_W-1; it SHALL never wrap.
REQ-024 On an edge with en=0, hist, fill and match_cnt SHALL hold their values, and z SHALL be 0.
REQ-025 A load with 1 <= cfg_len <= MAX_LEN SHALL update the configuration and set fill to 0 on that edge.
REQ-026 On a load edge, any x and en presented on the same edge SHALL be discarded; z SHALL still be evaluated against the old configuration.
REQ-027 A load with cfg_len = 0 or cfg_len > MAX_LEN SHALL leave the configuration and fill unchanged and SHALL set cfg_err = 1 for one cycle.

Reset
REQ-028 While rst=0 at an edge: hist=0, fill=0, match_cnt=0, cfg_err=0.
REQ-029 While rst=0 at an edge, the configuration SHALL reset to pat = 0b1010 (zero-extended), mask = 0b0001, len = 4, ovl = 0, i.e. a non-overlapping "101x" detector.
REQ-030 Reset SHALL take priority over load and en.
REQ-031 A reset in the middle of a sequence SHALL discard any partial match.

Verification
REQ-032 Default config, en=1, x = 1,0,1,0,1,1,0,1,1 -> z=1 only on bits 4 and 9; match_cnt = 2.
REQ-033 Load pat=101, mask=0, len=3, ovl=1, then x = 1,0,1,0,1 -> z=1 on bits 3 and 5; match_cnt = 2.
REQ-034 Repeat REQ-033 with ovl=0 -> z=1 on bit 3 only; match_cnt = 1.
REQ-035 Default config, x = 1,0,1, then rst=0 for one edge, then x = 0 -> z stays 0 and match_cnt = 0.
REQ-036 Default config, x = 1,0, then en=0 for 3 cycles with x toggling, then en=1 with x = 1,1 -> z=0 while en=0, and z=1 on the final bit.
REQ-037 Load with cfg_len = 0 -> cfg_err = 1 for exactly one cycle and the default "101x" detection is unchanged.
REQ-038 With CNT_W = 4, 20 matches -> match_cnt holds at 15.

Source files
------------

// File: rtl/mealy_seq_detect_param.sv
// Mealy serial pattern detector with programmable pattern, don't-care mask,
// length and overlap mode. z is combinational from registered history, x and en.
module mealy_seq_detect_param #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         x,
  input  logic                         en,
  input  logic                         load,
  input  logic [MAX_LEN-1:0]           cfg_pat,
  input  logic [MAX_LEN-1:0]           cfg_mask,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_ovl,
  output logic                         z,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cfg_err
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  // Reset configuration: non-overlapping "101x" detector.
  localparam logic [MAX_LEN-1:0] RstPat  = MAX_LEN'(4'b1010);
  localparam logic [MAX_LEN-1:0] RstMask = MAX_LEN'(4'b0001);
  localparam logic [LW-1:0]      RstLen  = LW'(4);
  localparam logic [LW-1:0]      FillMax = LW'(MAX_LEN - 1);

  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] len_mask;
  logic               fill_ok;
  logic               len_valid;

  // Match decode: compare the newest len bits of {hist, x} against the pattern.
  always_comb begin
    win      = {hist_q, x};
    len_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      len_mask[i] = (32'(i) < 32'(len_q));
    end
    // fill >= len-1, written without subtracting to avoid underflow
    fill_ok   = (32'(fill_q) + 32'd1) >= 32'(len_q);
    z         = en && fill_ok && (((win ^ pat_q) & ~mask_q & len_mask) == '0);
    len_valid = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);
  end

  // Next-state: counter, configuration load, history shift and fill tracking.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    mask_d = mask_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;

    if (z && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (load) begin
      // The bit presented with a load is dropped regardless of load validity.
      if (len_valid) begin
        pat_d  = cfg_pat;
        mask_d = cfg_mask;
        len_d  = cfg_len;
        ovl_d  = cfg_ovl;
        fill_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      hist_d = win[MAX_LEN-2:0];
      if (z && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + LW'(1);
      end
    end
  end

  // State register with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RstPat;
      mask_q <= RstMask;
      len_q  <= RstLen;
      ovl_q  <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      mask_q <= mask_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign match_cnt = cnt_q;
  assign cfg_err   = err_q;

endmodule
